imm_encoder: RTL and testbench
==============================

# imm_encoder

Instruction-word packer for the RISC-V core's program loader and self-test path: the inverse of the immediate extender. It takes a base instruction word (opcode, register and funct fields) plus a 32-bit immediate and the 2-bit `ImmSrc` type. It scatters the immediate into the RISC-V I/S/B/J bit positions and range-checks it. The packed word, a sequential word address and an error flag go out through a one-stage registered valid/ready pipeline toward instruction memory.

## Interface
- `ADDR_W`, default 32, width of the generated word address.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous: zero address counter and error state; has priority over any transfer in that cycle.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  input accepted when `in_valid && in_ready`.
- `ImmSrc`  in  2  00 I, 01 S, 10 B, 11 J.
- `base`  in  32  instruction word; its immediate bit positions are ignored.
- `imm`  in  32  signed immediate value.
- `out_valid`  out  1  registered word valid.
- `out_ready`  in  1  downstream accepts when `out_valid && out_ready`.
- `instr`  out  32  packed instruction.
- `addr`  out  ADDR_W  byte address of `instr`.
- `err`  out  1  range/alignment error for this word.
- `err_sticky`  out  1  set by any accepted erroneous word; cleared only by reset or `clr`.
- `err_cnt`  out  8  count of accepted erroneous words, saturating at 255.

## Operation
- Packing: every bit not listed below comes from `base`.
  - I type: `instr[31:20]` = `imm[11:0]`.
  - S type: `instr[31:25]` = `imm[11:5]`, `instr[11:7]` = `imm[4:0]`.
  - B type: `instr[31]` = `imm[12]`, `instr[30:25]` = `imm[10:5]`, `instr[11:8]` = `imm[4:1]`, `instr[7]` = `imm[11]`.
  - J type: `instr[31]` = `imm[20]`, `instr[30:21]` = `imm[10:1]`, `instr[20]` = `imm[11]`, `instr[19:12]` = `imm[19:12]`.
- Range checks; `err` = 1 if the check fails:
  - I and S: `imm[31:11]` are all equal.
  - B: `imm[31:12]` are all equal and `imm[0]` = 0.
  - J: `imm[31:20]` are all equal and `imm[0]` = 0.
- An erroneous word is still emitted, packed with the truncated bits above, and gets an address.
- Round-trip invariant: when `err` = 0, extending `instr` with the same `ImmSrc` returns exactly `imm`.
- Address counter:
  - `addr` on each emitted word equals the internal counter value at acceptance.
  - The counter increments by 4 per accepted input and wraps modulo 2^ADDR_W.
- Error counting: `err_sticky` and `err_cnt` update on input acceptance, not output handshake.

## Timing
- Reset values: `out_valid` 0, `instr` 0, `addr` 0, `err` 0, `err_sticky` 0, `err_cnt` 0, counter 0.
- `in_ready` is 1 while in reset.
- Pipeline states:
  - EMPTY: `out_valid` = 0.
  - FULL: `out_valid` = 1.
- Ready rule: `in_ready` = `!out_valid || out_ready`, a combinational path from `out_ready`. Back-to-back throughput is one word per cycle.
- Latency: a word accepted at edge N appears on the outputs after edge N, i.e. 1 cycle.
- Transitions:
  - EMPTY plus accept goes to FULL.
  - FULL with output handshake and no accept goes to EMPTY.
  - FULL with output handshake and accept in the same cycle stays FULL with the new word.
  - FULL with `out_ready` = 0 holds all outputs stable.
- `clr` behaviour:
  - Drops the pipeline to EMPTY.
  - Zeroes the counter, `err_sticky` and `err_cnt`.
  - Any input presented that cycle is discarded. `in_ready` may be high, but the word is not counted.
- Reset asserted mid-stream: the held word is lost, and outputs return to reset values immediately and asynchronously.
- `err_cnt` at 255 stays at 255. `err_sticky` still sets.
- `out_valid` never deasserts without an output handshake, `clr` or reset.

## Test plan
- I-type encode: `base` = 0x00000013, `imm` = 0xFFFFF800, ImmSrc 00 → next cycle `instr` = 0x80000013, `addr` = 0, `err` = 0. Then `imm` = 0x00000800 → `err` = 1, `err_sticky` = 1, `err_cnt` = 1.
- B/J alignment: ImmSrc 10, `imm` = 0x00000FFE, `base` = 0x00000063 → `instr` = 0x7E000FE3, `err` = 0. ImmSrc 11, `imm` = 0x00000003 → `err` = 1.
- Round trip: 1000 random in-range immediates per type, each fed through the extender model → recovered value equals `imm` every time. Out-of-range values assert `err` exactly when the check rule fails.
- Backpressure: stream 8 words with `out_ready` toggling 1,0,0,1 → no loss or duplication, outputs stable while stalled, `addr` sequence 0,4,…,28.
- Simultaneous accept and drain with `out_ready` = 1 → one word per cycle. Then `clr` while FULL with `in_valid` = 1 → next cycle `out_valid` = 0, counter 0, `err_cnt` 0.
- Async reset: assert `rst_n` low mid-stream between edges → outputs go to reset values before the next edge. Also drive 260 erroneous words → `err_cnt` saturates at 255.

Source files
------------

// File: rtl/imm_encoder.sv
// Packs a RISC-V immediate into an instruction word and range-checks it.
// One-stage valid/ready register toward instruction memory.
module imm_encoder #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ImmSrc,
  input  logic [31:0]       base,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] addr,
  output logic              err,
  output logic              err_sticky,
  output logic [7:0]        err_cnt
);

  typedef enum logic {
    EMPTY,
    FULL
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              accept;
  logic              drain;
  logic [31:0]       word;
  logic              bad;
  logic [ADDR_W-1:0] pc;

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready && !clr;
  assign drain     = out_valid && out_ready;

  // Scatter immediate; check that the dropped upper bits are pure sign.
  always_comb begin
    word = base;
    bad  = 1'b0;
    unique case (ImmSrc)
      2'b00: begin
        word[31:20] = imm[11:0];
        bad = !(&imm[31:11] || ~|imm[31:11]);
      end
      2'b01: begin
        word[31:25] = imm[11:5];
        word[11:7]  = imm[4:0];
        bad = !(&imm[31:11] || ~|imm[31:11]);
      end
      2'b10: begin
        word[31]    = imm[12];
        word[30:25] = imm[10:5];
        word[11:8]  = imm[4:1];
        word[7]     = imm[11];
        bad = !(&imm[31:12] || ~|imm[31:12])
              || imm[0];
      end
      2'b11: begin
        word[31]    = imm[20];
        word[30:21] = imm[10:1];
        word[20]    = imm[11];
        word[19:12] = imm[19:12];
        bad = !(&imm[31:20] || ~|imm[31:20])
              || imm[0];
      end
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      EMPTY: if (accept) state_nx = FULL;
      FULL:  if (drain && !accept) state_nx = EMPTY;
    endcase
    if (clr) state_nx = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= '0;
      addr  <= '0;
      err   <= 1'b0;
    end else if (accept) begin
      instr <= word;
      addr  <= pc;
      err   <= bad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= '0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (clr) begin
      pc         <= '0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (accept) begin
      pc <= pc + ADDR_W'(4);
      if (bad) begin
        err_sticky <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed vector and sequence bench for imm_encoder.
// Expected words are hand-computed or rebuilt with an extender model.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  ImmSrc;
  logic [31:0] base;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [31:0] addr;
  logic        err;
  logic        err_sticky;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  imm_encoder #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .ImmSrc(ImmSrc), .base(base), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .addr(addr), .err(err),
    .err_sticky(err_sticky), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  src;
    logic [31:0] base;
    logic [31:0] imm;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  vec_t tv[13];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ext(input logic [1:0] s,
                                      input logic [31:0] i);
    case (s)
      2'b00: ext = {{20{i[31]}}, i[31:20]};
      2'b01: ext = {{20{i[31]}}, i[31:25], i[11:7]};
      2'b10: ext = {{19{i[31]}}, i[31], i[7],
                    i[30:25], i[11:8], 1'b0};
      default: ext = {{11{i[31]}}, i[31], i[19:12],
                      i[20], i[30:21], 1'b0};
    endcase
  endfunction

  function automatic logic range_bad(input logic [1:0] s,
                                     input logic [31:0] i);
    case (s)
      2'b00, 2'b01: range_bad = i != {{20{i[11]}}, i[11:0]};
      2'b10: range_bad = (i != {{19{i[12]}}, i[12:0]}) || i[0];
      default: range_bad = (i != {{11{i[20]}}, i[20:0]}) || i[0];
    endcase
  endfunction

  function automatic logic [31:0] keep_mask(input logic [1:0] s);
    case (s)
      2'b00:   keep_mask = 32'h000F_FFFF;
      2'b01:   keep_mask = 32'h01FF_F07F;
      2'b10:   keep_mask = 32'h01FF_F07F;
      default: keep_mask = 32'h0000_0FFF;
    endcase
  endfunction

  initial begin
    int ecnt;
    logic [31:0] r;
    logic [31:0] hold_i;
    logic [31:0] hold_a;
    logic        stall;
    int sent;
    int recv;
    logic [3:0] pat;

    tv[0]  = '{2'b00, 32'h0000_0013, 32'hFFFF_F800, 32'h8000_0013, 1'b0};
    tv[1]  = '{2'b00, 32'h0000_0013, 32'h0000_0800, 32'h8000_0013, 1'b1};
    tv[2]  = '{2'b10, 32'h0000_0063, 32'h0000_0FFE, 32'h7E00_0FE3, 1'b0};
    tv[3]  = '{2'b11, 32'h0000_006F, 32'h0000_0003, 32'h0020_006F, 1'b1};
    tv[4]  = '{2'b01, 32'h0000_2023, 32'hFFFF_FFFC, 32'hFE00_2E23, 1'b0};
    tv[5]  = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0005, 32'h005F_FFFF, 1'b0};
    tv[6]  = '{2'b11, 32'h0000_00EF, 32'h0000_0800, 32'h0010_00EF, 1'b0};
    tv[7]  = '{2'b11, 32'h0000_006F, 32'hFFF0_0000, 32'h8000_006F, 1'b0};
    tv[8]  = '{2'b11, 32'h0000_006F, 32'h0010_0000, 32'h8000_006F, 1'b1};
    tv[9]  = '{2'b10, 32'h0000_0063, 32'h0000_1000, 32'h8000_0063, 1'b1};
    tv[10] = '{2'b10, 32'h0000_0063, 32'hFFFF_F000, 32'h8000_0063, 1'b0};
    tv[11] = '{2'b01, 32'h0000_0023, 32'h0000_07FF, 32'h7E00_0FA3, 1'b0};
    tv[12] = '{2'b00, 32'h0000_0013, 32'hFFFF_F7FF, 32'h7FF0_0013, 1'b1};

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; ImmSrc = 2'b00; base = '0; imm = '0;
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_err", {30'd0, err, err_sticky}, 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Directed table, streamed back-to-back
    ecnt = 0;
    for (int k = 0; k < 13; k++) begin
      in_valid = 1'b1;
      ImmSrc = tv[k].src; base = tv[k].base; imm = tv[k].imm;
      step();
      if (tv[k].err) ecnt++;
      chk($sformatf("tv%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("tv%0d_instr", k), instr, tv[k].instr);
      chk($sformatf("tv%0d_err", k), 32'(err), 32'(tv[k].err));
      chk($sformatf("tv%0d_addr", k), addr, 32'(4 * k));
      chk($sformatf("tv%0d_cnt", k), 32'(err_cnt), 32'(ecnt));
      chk($sformatf("tv%0d_sticky", k), 32'(err_sticky),
          32'(ecnt != 0));
    end
    in_valid = 1'b0;
    step();
    chk("tv_drain_valid", 32'(out_valid), 32'd0);

    // Random round trip through the extender model
    in_valid = 1'b1;
    for (int t = 0; t < 4; t++) begin
      for (int n = 0; n < 1000; n++) begin
        r = $urandom;
        ImmSrc = 2'(t);
        base = $urandom;
        if (n % 2 == 0) begin
          case (t)
            0, 1: imm = {{20{r[11]}}, r[11:0]};
            2: imm = {{19{r[12]}}, r[12:1], 1'b0};
            default: imm = {{11{r[20]}}, r[20:1], 1'b0};
          endcase
        end else if (n % 4 == 1) begin
          imm = r;
        end else begin
          imm = {{20{r[31]}}, r[11:0]} ^ (32'd1 << r[4:0]);
        end
        step();
        chk("rt_err", 32'(err), 32'(range_bad(ImmSrc, imm)));
        if (!range_bad(ImmSrc, imm))
          chk("rt_value", ext(ImmSrc, instr), imm);
        chk("rt_base", instr & keep_mask(ImmSrc),
            base & keep_mask(ImmSrc));
      end
    end
    in_valid = 1'b0;

    // Backpressure: 8 words, out_ready pattern 1,0,0,1
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_idle_cnt", 32'(err_cnt), 32'd0);
    pat = 4'b1001;
    sent = 0;
    recv = 0;
    ImmSrc = 2'b00;
    base = 32'h0000_0093;
    for (int c = 0; c < 100 && recv < 8; c++) begin
      out_ready = pat[3 - (c % 4)];
      in_valid = (sent < 8);
      imm = 32'(sent * 3 + 1);
      @(negedge clk);
      stall = out_valid && !out_ready;
      hold_i = instr;
      hold_a = addr;
      if (out_valid && out_ready) begin
        chk("bp_instr", instr,
            (32'(recv * 3 + 1) << 20) | 32'h93);
        chk("bp_addr", addr, 32'(recv * 4));
        recv++;
      end
      if (in_valid && in_ready) sent++;
      step();
      if (stall) begin
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_instr", instr, hold_i);
        chk("bp_hold_addr", addr, hold_a);
      end
    end
    chk("bp_recv", 32'(recv), 32'd8);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_no_dup", 32'(out_valid), 32'd0);

    // clr while FULL with a word presented
    in_valid = 1'b1;
    out_ready = 1'b0;
    imm = 32'h0000_0800;
    step();
    chk("clr_pre_valid", 32'(out_valid), 32'd1);
    chk("clr_pre_cnt", 32'(err_cnt), 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_cnt", 32'(err_cnt), 32'd0);
    chk("clr_sticky", 32'(err_sticky), 32'd0);
    out_ready = 1'b1;
    imm = 32'd7;
    step();
    chk("clr_addr0", addr, 32'd0);
    chk("clr_next_instr", instr, 32'h0070_0093);
    step();
    chk("clr_addr4", addr, 32'd4);

    // Async reset between edges
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_instr", instr, 32'd0);
    chk("arst_addr", addr, 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    step();

    // Saturation of the error counter
    in_valid = 1'b1;
    ImmSrc = 2'b00;
    imm = 32'h0000_0800;
    for (int k = 0; k < 260; k++) begin
      step();
      chk("sat_cnt", 32'(err_cnt), (k < 254) ? 32'(k + 1) : 32'd255);
    end
    in_valid = 1'b0;
    step();
    chk("sat_sticky", 32'(err_sticky), 32'd1);
    chk("sat_final", 32'(err_cnt), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
